// File: rtl/mem_region_decoder_if.sv
// Bus bundle between an access master and mem_region_decoder.
//
// Parameters:
//   ADDR_W       address width
//   REGION_BITS  log2 of region size
//   NUM_CS       number of chip-select lines
//
// Signals:
//   req        master -> decoder  access request
//   addr       master -> decoder  access address
//   cs_enable  master -> decoder  per-region enable mask
//   cs_n       decoder -> master  active-low chip selects
//   region     decoder -> master  index of last sampled region
//   busy       decoder -> master  decoder not idle
//   ack        decoder -> master  one-cycle access-complete pulse
//   err        decoder -> master  one-cycle unmapped/disabled pulse
interface mem_region_decoder_if #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REGION_BITS = 13,
    parameter int unsigned NUM_CS      = 4
) ();

    logic                          req;
    logic [ADDR_W-1:0]             addr;
    logic [NUM_CS-1:0]             cs_enable;
    logic [NUM_CS-1:0]             cs_n;
    logic [ADDR_W-REGION_BITS-1:0] region;
    logic                          busy;
    logic                          ack;
    logic                          err;

    modport master (
        output req,
        output addr,
        output cs_enable,
        input  cs_n,
        input  region,
        input  busy,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        input  cs_enable,
        output cs_n,
        output region,
        output busy,
        output ack,
        output err
    );

endinterface

// File: rtl/mem_region_decoder.sv
// Memory region decoder with timed chip-select generation.
//
// The address space is split into 2^REGION_BITS-sized regions. A request sampled
// in idle either drives the matching active-low chip select for WAIT_CYCLES+1
// cycles followed by a one-cycle ack, or, when the region is unmapped or disabled,
// produces a one-cycle err. All outputs are registered.
//
// Ports:
//   clk     rising-edge clock
//   nRESET  asynchronous active-low reset
//   bus     mem_region_decoder_if slave modport (req/addr/cs_enable in;
//           cs_n/region/busy/ack/err out)
module mem_region_decoder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REGION_BITS = 13,
    parameter int unsigned NUM_CS      = 4,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 nRESET,
    mem_region_decoder_if.slave  bus
);

    localparam int unsigned IDX_W = ADDR_W - REGION_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StErr
    } state_e;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic [IDX_W-1:0]  region_q;
    logic              busy_q;
    logic              ack_q;
    logic              err_q;

    logic [IDX_W-1:0]  idx;
    logic [NUM_CS-1:0] sel;
    logic              valid;

    // Decode by comparing against each chip-select number, so an index beyond
    // NUM_CS simply selects nothing instead of indexing out of range.
    always_comb begin
        idx = bus.addr[ADDR_W-1:REGION_BITS];
        sel = '0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i] = 1'b1;
            end
        end
        valid = |(sel & bus.cs_enable);
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            cs_n_q   <= '1;
            region_q <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        region_q <= idx;
                        busy_q   <= 1'b1;
                        if (valid) begin
                            state_q <= StAccess;
                            cs_n_q  <= ~sel;
                            cnt_q   <= 8'(WAIT_CYCLES);
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    // Chip select stays low through the cycle where the count reaches 0,
                    // giving WAIT_CYCLES+1 low cycles in total.
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= StDone;
                        cs_n_q  <= '1;
                        ack_q   <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                StErr: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cs_n_q  <= '1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cs_n   = cs_n_q;
    assign bus.region = region_q;
    assign bus.busy   = busy_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Self-checking bench for mem_region_decoder: reset state, table of directed
// accesses, held-request and mid-access reset sequences, random accesses against
// a transaction-level model, and a WAIT_CYCLES=0 instance.
module tb_mem_region_decoder;

    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic nRESET;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_region_decoder_if #(.ADDR_W(16), .REGION_BITS(13), .NUM_CS(4)) bus ();
    mem_region_decoder_if #(.ADDR_W(16), .REGION_BITS(13), .NUM_CS(4)) bus0 ();

    mem_region_decoder #(
        .ADDR_W(16), .REGION_BITS(13), .NUM_CS(4), .WAIT_CYCLES(W)
    ) dut (
        .clk(clk), .nRESET(nRESET), .bus(bus)
    );

    mem_region_decoder #(
        .ADDR_W(16), .REGION_BITS(13), .NUM_CS(4), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .nRESET(nRESET), .bus(bus0)
    );

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  en;
        logic        valid;
        logic [3:0]  cs_n;
        logic [2:0]  region;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: region index is the address divided by region size.
    function automatic void model(input logic [15:0] a, input logic [3:0] e,
                                  output logic v, output logic [3:0] cs,
                                  output logic [2:0] r);
        int unsigned ri;
        ri = int'(a) / 8192;
        r  = 3'(ri);
        v  = (ri < 4) ? e[ri[1:0]] : 1'b0;
        cs = v ? ~(4'b0001 << ri) : 4'b1111;
    endfunction

    // Called at a negedge with the DUT idle. Junk is driven on the inputs
    // while busy; it must have no effect.
    task automatic run_txn(input string nm, input logic [15:0] a, input logic [3:0] e,
                           input logic v, input logic [3:0] ecs, input logic [2:0] er);
        int len;
        bus.req       = 1'b1;
        bus.addr      = a;
        bus.cs_enable = e;
        @(posedge clk);
        len = v ? int'(W) + 3 : 2;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk({nm, " region"}, 32'(bus.region), 32'(er));
            chk({nm, " busy"}, 32'(bus.busy), 32'(k < len));
            chk({nm, " ack"}, 32'(bus.ack), 32'(v && k == int'(W) + 2));
            chk({nm, " err"}, 32'(bus.err), 32'(!v && k == 1));
            chk({nm, " cs_n"}, 32'(bus.cs_n), 32'((v && k <= int'(W) + 1) ? ecs : 4'hF));
            if (k < len) begin
                bus.req       = 1'($urandom);
                bus.addr      = 16'($urandom);
                bus.cs_enable = 4'($urandom);
            end else begin
                bus.req = 1'b0;
            end
        end
    endtask

    initial begin
        logic       mv;
        logic [3:0] mcs;
        logic [2:0] mr;
        logic [15:0] ra;
        logic [3:0]  re;

        vecs[0] = '{16'h1234, 4'b1111, 1'b1, 4'b1110, 3'd0};
        vecs[1] = '{16'h2000, 4'b1111, 1'b1, 4'b1101, 3'd1};
        vecs[2] = '{16'h3FFF, 4'b1111, 1'b1, 4'b1101, 3'd1};
        vecs[3] = '{16'hA000, 4'b1111, 1'b0, 4'b1111, 3'd5};
        vecs[4] = '{16'h4000, 4'b1011, 1'b0, 4'b1111, 3'd2};
        vecs[5] = '{16'h4000, 4'b1111, 1'b1, 4'b1011, 3'd2};
        vecs[6] = '{16'h6000, 4'b0111, 1'b0, 4'b1111, 3'd3};
        vecs[7] = '{16'hE000, 4'b1111, 1'b0, 4'b1111, 3'd7};
        vecs[8] = '{16'h6000, 4'b1111, 1'b1, 4'b0111, 3'd3};

        nRESET         = 1'b0;
        bus.req        = 1'b0;
        bus.addr       = 16'h0;
        bus.cs_enable  = 4'h0;
        bus0.req       = 1'b0;
        bus0.addr      = 16'h0;
        bus0.cs_enable = 4'h0;

        repeat (3) @(negedge clk);
        chk("rst cs_n", 32'(bus.cs_n), 32'hF);
        chk("rst region", 32'(bus.region), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        chk("rst ack", 32'(bus.ack), 32'h0);
        chk("rst err", 32'(bus.err), 32'h0);
        chk("rst0 cs_n", 32'(bus0.cs_n), 32'hF);
        nRESET = 1'b1;

        // Directed table; consecutive entries run back-to-back.
        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].en, vecs[i].valid,
                    vecs[i].cs_n, vecs[i].region);
        end

        // Held request is re-sampled on the first idle cycle: period W+3.
        bus.req       = 1'b1;
        bus.addr      = 16'h0000;
        bus.cs_enable = 4'hF;
        @(posedge clk);
        for (int k = 1; k <= 2 * (int'(W) + 3); k++) begin
            int ph;
            @(negedge clk);
            ph = (k - 1) % (int'(W) + 3);
            chk("held cs_n", 32'(bus.cs_n), 32'((ph <= int'(W)) ? 4'hE : 4'hF));
            chk("held ack", 32'(bus.ack), 32'(ph == int'(W) + 1));
            chk("held busy", 32'(bus.busy), 32'(ph != int'(W) + 2));
        end
        bus.req = 1'b0;

        // Reset during the second ACCESS cycle.
        bus.req       = 1'b1;
        bus.addr      = 16'h2000;
        bus.cs_enable = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("mid cs_n before", 32'(bus.cs_n), 32'hD);
        #2 nRESET = 1'b0;
        #1;
        chk("mid cs_n async", 32'(bus.cs_n), 32'hF);
        chk("mid busy async", 32'(bus.busy), 32'h0);
        chk("mid region async", 32'(bus.region), 32'h0);
        @(negedge clk);
        nRESET = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post-rst ack", 32'(bus.ack), 32'h0);
            chk("post-rst busy", 32'(bus.busy), 32'h0);
            chk("post-rst cs_n", 32'(bus.cs_n), 32'hF);
        end
        run_txn("after-rst", 16'h1234, 4'hF, 1'b1, 4'hE, 3'd0);

        // Random accesses against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            re = 4'($urandom);
            model(ra, re, mv, mcs, mr);
            run_txn($sformatf("rnd%0d", i), ra, re, mv, mcs, mr);
        end

        // WAIT_CYCLES=0 instance.
        bus0.req       = 1'b1;
        bus0.addr      = 16'h6000;
        bus0.cs_enable = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus0.req = 1'b0;
        chk("w0 cs_n k1", 32'(bus0.cs_n), 32'h7);
        chk("w0 ack k1", 32'(bus0.ack), 32'h0);
        chk("w0 busy k1", 32'(bus0.busy), 32'h1);
        chk("w0 region", 32'(bus0.region), 32'h3);
        @(negedge clk);
        chk("w0 cs_n k2", 32'(bus0.cs_n), 32'hF);
        chk("w0 ack k2", 32'(bus0.ack), 32'h1);
        @(negedge clk);
        chk("w0 ack k3", 32'(bus0.ack), 32'h0);
        chk("w0 busy k3", 32'(bus0.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_region_decoder.md
MEM_REGION_DECODER -- requirements
Module: mem_region_decoder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_W, 16, address width
- REGION_BITS, 13, log2 of region size (default 8 KiB regions: 0x0000-0x1FFF, 0x2000-0x3FFF, ...)
- NUM_CS, 4, number of chip-select outputs; legal range 1..2^(ADDR_W-REGION_BITS)
- WAIT_CYCLES, 2, extra cycles chip select is held; legal range 0..255
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  clock, rising edge
- nRESET  in  1  reset, asynchronous, active-low
- req  in  1  access request, sampled only in IDLE
- addr  in  ADDR_W  access address, sampled with req
- cs_enable  in  NUM_CS  per-region enable, sampled with req
- cs_n  out  NUM_CS  chip selects, active-low, at most one low
- region  out  ADDR_W-REGION_BITS  index of last sampled region
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle pulse, access completed
- err  out  1  one-cycle pulse, unmapped or disabled region

Function
REQ-003 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-004 Region index SHALL equal addr[ADDR_W-1:REGION_BITS] of the sampled address.
REQ-005 A region SHALL be valid iff index < NUM_CS and cs_enable[index]=1 at the sampling edge.
REQ-006 The FSM SHALL have exactly 4 states: IDLE, ACCESS, DONE, ERR.
REQ-007 IDLE: req=0 -> stay; req=1 and valid -> ACCESS; req=1 and invalid -> ERR. region SHALL update on any sampled req.
REQ-008 On the IDLE->ACCESS transition, cs_n[index] SHALL go low and the wait counter SHALL load WAIT_CYCLES.
REQ-009 ACCESS: counter>0 -> decrement and stay; counter=0 -> DONE.
REQ-010 cs_n[index] SHALL remain low for exactly WAIT_CYCLES+1 consecutive cycles, then return high on entry to DONE.
REQ-011 DONE SHALL last one cycle, with ack=1, all cs_n high, then return to IDLE.
REQ-012 ERR SHALL last one cycle, with err=1, all cs_n high, then return to IDLE.
REQ-013 Request-to-ack latency SHALL be WAIT_CYCLES+2 cycles from the sampling edge; back-to-back accesses SHALL be spaced WAIT_CYCLES+3 cycles apart.
REQ-014 req, addr and cs_enable SHALL be ignored while busy=1; a held req SHALL be re-sampled on the first IDLE cycle.
REQ-015 Changes to addr or cs_enable during ACCESS SHALL NOT affect cs_n or timing.
REQ-016 ack and err SHALL never be high in the same cycle, and neither SHALL be high while any cs_n is low.
REQ-017 The counter SHALL be 8 bits wide and SHALL never underflow.

Reset
REQ-018 nRESET low SHALL asynchronously force: state IDLE, cs_n all ones, region 0, busy 0, ack 0, err 0, counter 0.
REQ-019 Reset asserted mid-ACCESS SHALL release cs_n immediately, without waiting for a clock edge, and SHALL suppress that access's ack.
REQ-020 After nRESET deasserts, the first req SHALL be sampled on the first rising edge at which it is high.

Verification
REQ-021 Defaults, cs_enable=4'b1111, req with addr=16'h1234 -> region=0, cs_n=4'b1110 for 3 cycles, then ack for 1 cycle.
REQ-022 Defaults, addr=16'h2000 then 16'h3FFF, back-to-back -> cs_n=4'b1101 both times, accesses 5 cycles apart.
REQ-023 Defaults, addr=16'hA000 (index 5 >= NUM_CS) -> region=5, err pulse one cycle after sampling, cs_n stays 4'b1111.
REQ-024 Defaults, cs_enable=4'b1011, addr=16'h4000 -> err pulse, no cs_n low; repeat with cs_enable=4'b1111 -> cs_n=4'b1011, then ack.
REQ-025 WAIT_CYCLES=0, addr=16'h6000 -> cs_n=4'b0111 for 1 cycle, ack on the next cycle; latency 2 cycles.
REQ-026 nRESET pulsed low during cycle 2 of ACCESS -> cs_n=4'b1111 immediately, no ack, busy=0; the next req is serviced normally.
